// File: rtl/ifetch_seq32_pkg.sv
// Shared fetch-stage definitions: FSM state encodings,
// reset PC default, NOP word and a word-alignment helper.
package ifetch_seq32_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_WAIT  = 2'b01,
        ST_EXEC  = 2'b10
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

    function automatic logic [31:0] word_align(
        input logic [31:0] a
    );
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/ifetch_next_pc.sv
// Next-PC priority mux: jr > j/jal > taken branch > PC+4.
// Ports: controller flags, Zero, branch/jr targets, PC+4,
//        jump index (Instruction[25:0]) in; next_pc out.
module ifetch_next_pc
    import ifetch_seq32_pkg::*;
(
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jr,
    input  logic        Zero,
    input  logic [31:0] Addr_result,
    input  logic [31:0] Read_data_1,
    input  logic [31:0] pc_plus4,
    input  logic [25:0] jump_index,
    output logic [31:0] next_pc
);

    logic take_br;

    assign take_br = (Branch & Zero) | (nBranch & ~Zero);

    // Several flags at once is illegal from the controller;
    // the priority order silently resolves it.
    always_comb begin
        next_pc = pc_plus4;
        priority case (1'b1)
            Jr:          next_pc = word_align(Read_data_1);
            (Jmp | Jal): next_pc = {pc_plus4[31:28],
                                    jump_index, 2'b00};
            take_br:     next_pc = word_align(Addr_result);
            default:     next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/ifetch_seq32.sv
// Instruction-fetch stage: PC, imem request FSM with timeout,
// instruction latch and next-PC update.
// Ports: clock/rst_n; controller flags, Zero, Addr_result,
//        Read_data_1, stall; imem_rdata/imem_ready in;
//        imem_req/imem_addr, Instruction, Opcode,
//        Function_opcode, branch_base_addr, link_addr,
//        instr_valid, fetch_err out.
module ifetch_seq32
    import ifetch_seq32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jr,
    input  logic        Zero,
    input  logic [31:0] Addr_result,
    input  logic [31:0] Read_data_1,
    input  logic        stall,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] Instruction,
    output logic [5:0]  Opcode,
    output logic [5:0]  Function_opcode,
    output logic [31:0] branch_base_addr,
    output logic [31:0] link_addr,
    output logic        instr_valid,
    output logic        fetch_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    fetch_state_e  state;
    logic [31:0]   pc;
    logic [31:0]   pc_plus4;
    logic [31:0]   next_pc;
    logic [CW-1:0] wait_cnt;

    assign pc_plus4         = pc + 32'd4;
    assign imem_addr        = pc;
    assign branch_base_addr = pc_plus4;
    assign Opcode           = Instruction[31:26];
    assign Function_opcode  = Instruction[5:0];

    ifetch_next_pc u_next_pc (
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Jr          (Jr),
        .Zero        (Zero),
        .Addr_result (Addr_result),
        .Read_data_1 (Read_data_1),
        .pc_plus4    (pc_plus4),
        .jump_index  (Instruction[25:0]),
        .next_pc     (next_pc)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            Instruction <= NOP_WORD;
            link_addr   <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            imem_req  <= 1'b0;
            fetch_err <= 1'b0;
            unique case (state)
                ST_FETCH: begin
                    imem_req <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_ready) begin
                        Instruction <= imem_rdata;
                        link_addr   <= pc_plus4;
                        instr_valid <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= ST_EXEC;
                    end else if (wait_cnt == CNT_LAST) begin
                        // Give up and reissue the same PC.
                        fetch_err <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= ST_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_EXEC: begin
                    if (!stall) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        state       <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_seq32.sv
// Self-checking bench for ifetch_seq32: directed programs with a
// behavioural next-PC model and a per-cycle output comparator.
module tb_ifetch_seq32;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        Branch = 0, nBranch = 0, Jmp = 0, Jal = 0, Jr = 0;
    logic        Zero = 0;
    logic [31:0] Addr_result = '0, Read_data_1 = '0;
    logic        stall = 0;
    logic [31:0] imem_rdata = '0;
    logic        imem_ready = 0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] Instruction;
    logic [5:0]  Opcode, Function_opcode;
    logic [31:0] branch_base_addr, link_addr;
    logic        instr_valid, fetch_err;

    ifetch_seq32 dut (
        .clock            (clock),
        .rst_n            (rst_n),
        .Branch           (Branch),
        .nBranch          (nBranch),
        .Jmp              (Jmp),
        .Jal              (Jal),
        .Jr               (Jr),
        .Zero             (Zero),
        .Addr_result      (Addr_result),
        .Read_data_1      (Read_data_1),
        .stall            (stall),
        .imem_rdata       (imem_rdata),
        .imem_ready       (imem_ready),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .Instruction      (Instruction),
        .Opcode           (Opcode),
        .Function_opcode  (Function_opcode),
        .branch_base_addr (branch_base_addr),
        .link_addr        (link_addr),
        .instr_valid      (instr_valid),
        .fetch_err        (fetch_err)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;
    logic chk_en = 1'b0;

    // Architectural expectations
    logic [31:0] exp_pc = '0;
    logic [31:0] exp_instr = '0;
    logic [31:0] exp_link = '0;

    logic [5:0]  last_op;
    logic [31:0] last_link;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %08h want %08h",
                      name, act, req);
    endtask

    // Next PC from the ISA rules, plain arithmetic.
    function automatic logic [31:0] model_next(
        input logic [31:0] pc, input logic [31:0] instr,
        input logic jr, input logic jmp, input logic jal,
        input logic br, input logic nbr, input logic z,
        input logic [31:0] ar, input logic [31:0] rd1);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (jr) return rd1 - (rd1 % 4);
        if (jmp || jal)
            return (seq & 32'hF000_0000)
                 + (instr % 32'h0400_0000) * 4;
        if ((br && z) || (nbr && !z)) return ar - (ar % 4);
        return seq;
    endfunction

    // Per-cycle comparator
    always @(negedge clock) begin
        if (chk_en && rst_n) begin
            check("imem_addr", imem_addr, exp_pc);
            if (instr_valid) begin
                check("instr", Instruction, exp_instr);
                check("opcode", {26'b0, Opcode},
                      {26'b0, exp_instr[31:26]});
                check("funct", {26'b0, Function_opcode},
                      {26'b0, exp_instr[5:0]});
                check("bbase", branch_base_addr,
                      exp_pc + 32'd4);
                check("link", link_addr, exp_link);
                check("req_in_exec", {31'b0, imem_req}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 40 && imem_req !== 1'b1; i++)
            tick();
        check("req_seen", {31'b0, imem_req}, 32'd1);
    endtask

    // f = {jr, jmp, jal, br, nbr}
    task automatic run_instr(input logic [31:0] word,
                             input int lat, input int nstall,
                             input logic [4:0] f, input logic z,
                             input logic [31:0] ar,
                             input logic [31:0] rd1,
                             input logic [31:0] lit_next);
        logic [31:0] nxt;
        wait_req();
        repeat (lat) tick();
        imem_rdata = word;
        imem_ready = 1'b1;
        exp_instr  = word;
        exp_link   = exp_pc + 32'd4;
        tick();
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("valid", {31'b0, instr_valid}, 32'd1);
        {Jr, Jmp, Jal, Branch, nBranch} = f;
        Zero        = z;
        Addr_result = ar;
        Read_data_1 = rd1;
        last_op   = Opcode;
        last_link = link_addr;
        if (nstall > 0) begin
            stall = 1'b1;
            imem_ready = 1'b1;
            for (int s = 0; s < nstall; s++) begin
                tick();
                imem_ready = 1'b0;
                check("stall_valid", {31'b0, instr_valid}, 32'd1);
                check("stall_req", {31'b0, imem_req}, 32'd0);
            end
            stall = 1'b0;
        end
        nxt = model_next(exp_pc, word, f[4], f[3], f[2],
                         f[1], f[0], z, ar, rd1);
        tick();
        exp_pc = nxt;
        {Jr, Jmp, Jal, Branch, nBranch} = '0;
        check("next_lit", imem_addr, lit_next);
        check("valid_drop", {31'b0, instr_valid}, 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_err", {31'b0, fetch_err}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", Instruction, 32'h0);
        check("rst_link", link_addr, 32'h0);

        @(negedge clock);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();
        check("req_cycle1", {31'b0, imem_req}, 32'd1);
        check("addr_cycle1", imem_addr, 32'h0);

        run_instr(32'h2008_0005, 1, 0, 5'b0, 0, 0, 0, 32'h4);
        check("addi_op", {26'b0, last_op}, 32'h8);
        run_instr(32'h0, 0, 0, 5'b0, 0, 0, 0, 32'h8);
        run_instr(32'h0, 2, 0, 5'b0, 0, 0, 0, 32'hC);
        run_instr(32'h0, 0, 0, 5'b0, 0, 0, 0, 32'h10);
        // beq taken
        run_instr(32'h1000_000B, 0, 0, 5'b00010, 1,
                  32'h40, 0, 32'h40);
        // jr back with unaligned rs
        run_instr(32'h0200_0008, 0, 0, 5'b10000, 0,
                  0, 32'h13, 32'h10);
        // beq not taken
        run_instr(32'h1000_000B, 1, 0, 5'b00010, 0,
                  32'h40, 0, 32'h14);
        // bne taken, unaligned target
        run_instr(32'h1400_000A, 0, 0, 5'b00001, 0,
                  32'h43, 0, 32'h40);
        run_instr(32'h0200_0008, 0, 0, 5'b10000, 0,
                  0, 32'h0040_0020, 32'h0040_0020);
        // jal
        run_instr(32'h0C00_0100, 0, 0, 5'b00100, 0,
                  0, 0, 32'h0000_0400);
        check("jal_link", last_link, 32'h0040_0024);
        run_instr(32'h0200_0008, 0, 0, 5'b10000, 0,
                  0, 32'h123, 32'h120);
        // jr + j together: jr wins
        run_instr(32'h0800_0080, 0, 0, 5'b11000, 0,
                  0, 32'h404, 32'h404);
        // jal + beq taken: jump wins
        run_instr(32'h0C00_0040, 0, 0, 5'b00110, 1,
                  32'h80, 0, 32'h100);
        // stall for 5 cycles with a stray ready
        run_instr(32'h0109_5020, 0, 5, 5'b0, 0, 0, 0, 32'h104);

        // memory never ready
        wait_req();
        for (n = 1; n <= 40; n++) begin
            tick();
            if (fetch_err) break;
        end
        check("timeout_cycles", n, 16);
        tick();
        check("err_pulse", {31'b0, fetch_err}, 32'd0);
        check("reissue_req", {31'b0, imem_req}, 32'd1);
        check("reissue_addr", imem_addr, 32'h104);

        run_instr(32'h0200_0008, 0, 0, 5'b10000, 0,
                  0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
        // PC+4 wraps to zero
        run_instr(32'h0, 0, 0, 5'b0, 0, 0, 0, 32'h0);
        run_instr(32'h0, 0, 0, 5'b0, 0, 0, 0, 32'h4);

        // reset mid-WAIT
        wait_req();
        tick();
        rst_n     = 1'b0;
        exp_pc    = 32'h0;
        exp_instr = 32'h0;
        #1;
        check("midrst_addr", imem_addr, 32'h0);
        check("midrst_valid", {31'b0, instr_valid}, 32'd0);
        check("midrst_req", {31'b0, imem_req}, 32'd0);
        repeat (2) tick();
        // stray ready while in FETCH is ignored
        imem_rdata = 32'hBAD0_BAD0;
        imem_ready = 1'b1;
        rst_n      = 1'b1;
        tick();
        imem_ready = 1'b0;
        check("late_ready", {31'b0, instr_valid}, 32'd0);
        run_instr(32'h2008_0005, 2, 0, 5'b0, 0, 0, 0, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ifetch_seq32.md
Name: ifetch_seq32

Overview:
- Instruction-fetch stage directly upstream of the main controller and decoder in the single-cycle MIPS CPU.
- Holds the PC and issues requests to a variable-latency instruction memory.
- Latches the returned word and presents Opcode/Function fields for one execute window.
- Computes the next PC from the controller's Branch/nBranch/Jmp/Jal/Jr outputs, the ALU Zero flag and the branch target.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- TIMEOUT, 16, maximum WAIT cycles before `fetch_err` pulses and the request is reissued.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Branch  in  1  controller: beq.
- nBranch  in  1  controller: bne.
- Jmp  in  1  controller: j.
- Jal  in  1  controller: jal.
- Jr  in  1  controller: jr.
- Zero  in  1  ALU equality flag.
- Addr_result  in  32  ALU branch target.
- Read_data_1  in  32  rs value, used as the jr target.
- stall  in  1  holds EXEC (e.g. IO wait); sampled only in EXEC.
- imem_rdata  in  32  instruction word from instruction memory.
- imem_ready  in  1  imem_rdata valid this cycle.
- imem_req  out  1  fetch request pulse.
- imem_addr  out  32  word address = PC.
- Instruction  out  32  latched instruction.
- Opcode  out  6  Instruction[31:26].
- Function_opcode  out  6  Instruction[5:0].
- branch_base_addr  out  32  PC+4.
- link_addr  out  32  PC+4 captured at latch time, for the jal write to $31.
- instr_valid  out  1  high in EXEC; controller outputs are meaningful only then.
- fetch_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset values (asynchronous, rst_n=0): PC=RESET_PC; Instruction=32'h0 (nop); link_addr=0; imem_req=0; instr_valid=0; fetch_err=0; state=FETCH.
- States and transitions:
  - FETCH: imem_req=1 for exactly one cycle, imem_addr=PC; go to WAIT.
  - WAIT: imem_ready is sampled only here.
    - imem_ready=1: Instruction<=imem_rdata, link_addr<=PC+4, go to EXEC.
    - Otherwise increment the wait counter.
    - Counter reaches TIMEOUT: pulse fetch_err, clear counter, go to FETCH (same PC).
  - EXEC: instr_valid=1.
    - stall=1: hold everything, including PC and Instruction.
    - stall=0: PC<=next_pc, go to FETCH.
- Latency: minimum 3 cycles per instruction (FETCH, WAIT with ready, EXEC).
- imem_ready in FETCH or EXEC is ignored.
- next_pc priority, highest first:
  - Jr: {Read_data_1[31:2],2'b00}, low bits forced to 0.
  - Jmp or Jal: {PC_plus4[31:28], Instruction[25:0], 2'b00}.
  - Branch&Zero or nBranch&!Zero: {Addr_result[31:2],2'b00}.
  - Otherwise: PC+4.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0. PC[1:0] is always 0.
- Simultaneous control flags, which are illegal from the controller: the priority above resolves them; no error is raised.
- Reset asserted mid-WAIT or mid-EXEC: state, PC and outputs return to reset values immediately. A late imem_ready after reset release is ignored unless the state is WAIT.
- Combinational outputs:
  - Opcode, Function_opcode and branch_base_addr are combinational from Instruction and PC.
  - They remain stable through EXEC, including stalled cycles.

Decomposition:
- Shared defines file (alongside the existing opcode defines): FETCH/WAIT/EXEC state encodings (2-bit), RESET_PC default, NOP word.
- One natural sub-module: ifetch_next_pc, purely combinational, containing the priority mux and the jump/branch target formation. Unit-testable on its own.
- The FSM, PC register, Instruction register and timeout counter stay in ifetch_seq32.

Test Plan:
1. Reset release with RESET_PC=0 and memory ready one cycle after the request returning 32'h2008_0005 (addi) -> imem_req pulses at cycle 1 with imem_addr=0; instr_valid at cycle 3; Opcode=6'b001000; next imem_addr=4.
2. beq at PC=0x10 with Zero=1 and Addr_result=0x40 -> next imem_addr=0x40. Same instruction with Zero=0 -> 0x14. bne with Zero=0 and Addr_result=0x40 -> 0x40.
3. jal at PC=0x0040_0020, Instruction[25:0]=26'h0000100 -> link_addr=0x0040_0024; next imem_addr=0x0000_0400.
4. jr with Read_data_1=0x0000_0123 -> next imem_addr=0x0000_0120. jr and Jmp asserted together -> the jr target wins.
5. stall held high for 5 EXEC cycles -> instr_valid stays 1; Instruction and PC unchanged; no imem_req. The request issues on the cycle after stall drops.
6. Memory never ready -> fetch_err pulses after 16 WAIT cycles and imem_req reissues the same address. Separately, rst_n pulsed low mid-WAIT -> PC=RESET_PC and instr_valid=0 immediately.
